seven_seg_scan_mux: RTL and testbench

Parametrised N-digit multiplexed seven-segment driver. It scans NUM_DIGITS hex digits, one digit per time slot. Over the previous fixed two-digit alternation it adds:
- load-qualified shadow registers for the display data
- per-digit decimal points and per-digit enables
- optional leading-zero blanking
- selectable output polarity
- a frame-start strobe

It sits between the UART RX byte/data-valid path (or any other data source) and the board's segment and digit-select pins.

---
 rtl/seven_seg_scan_mux.sv | 195 +++++++++++++++++++
 tb/tb_seven_seg_scan_mux.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux
// Multiplexed N-digit seven-segment driver. One hex digit is shown per time
// slot; display data and decimal points come from load-qualified shadow
// registers, while the per-digit enables are sampled live at each slot start.
// All outputs are registered, and polarity inversion is folded into that
// register stage, so no input reaches a pin combinationally.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_DIG = 1'b1,
    parameter bit BLANK_LEADING  = 1'b0
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Load,
    input  logic [4*NUM_DIGITS-1:0] i_Data,
    input  logic [NUM_DIGITS-1:0]   i_DP,
    input  logic [NUM_DIGITS-1:0]   i_Digit_En,
    output logic [6:0]              o_Segment,
    output logic                    o_DP,
    output logic [NUM_DIGITS-1:0]   o_Digit_Sel,
    output logic                    o_Frame
);

    // A single-digit build still needs a one-bit index register.
    localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // "Off" pin levels. Because lit = logical ^ off, these also serve as the
    // XOR masks that apply the selected polarity.
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW_SEG}};
    localparam logic                  DP_OFF  = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{ACTIVE_LOW_DIG}};

    // Slot timer and scan index.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             advance;

    // Shadow copies of the display data.
    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

    // Registered pin drivers.
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  frame_q, frame_d;

    // Per-slot selection of the digit being scanned.
    logic [NUM_DIGITS-1:0] leading_zero;
    logic                  upper_zero;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] cur_onehot;

    // Logical hex-to-segment map, bit0 = a through bit6 = g, 1 = lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Slot timer wraps every CLKS_PER_DIGIT cycles; the last count of a slot
    // is the advance cycle, which also steps the scan index.
    always_comb begin
        advance = (cnt_q == CNT_LAST);
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (advance) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Shadow registers only change on a load; an advance on the same cycle
    // reads the old shadow contents, so new data shows from the next slot.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (i_Load) begin
            shadow_data_d = i_Data;
            shadow_dp_d   = i_DP;
        end
    end

    // Walk down from the top digit; a digit is a leading zero while it and
    // everything above it is zero. Digit 0 is always allowed to show.
    always_comb begin
        leading_zero = '0;
        upper_zero   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (shadow_data_q[4*k +: 4] == 4'h0);
            if (k > 0) begin
                leading_zero[k] = upper_zero & BLANK_LEADING;
            end
        end
    end

    // Pick out the nibble, DP, live enable and blanking flag of the digit
    // that the next advance will display.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_lz     = 1'b0;
        cur_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nibble    = shadow_data_q[4*k +: 4];
                cur_dp        = shadow_dp_q[k];
                cur_en        = i_Digit_En[k];
                cur_lz        = leading_zero[k];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    // Output stage holds between advances; on an advance it loads either the
    // decoded digit or the all-off pattern, with polarity applied here.
    always_comb begin
        seg_d   = seg_q;
        dp_d    = dp_q;
        sel_d   = sel_q;
        frame_d = 1'b0;
        if (advance) begin
            frame_d = (idx_q == '0);
            if (cur_en && !cur_lz) begin
                seg_d = hex_to_seg(cur_nibble) ^ SEG_OFF;
                dp_d  = cur_dp ^ DP_OFF;
                sel_d = cur_onehot ^ SEL_OFF;
            end else begin
                seg_d = SEG_OFF;
                dp_d  = DP_OFF;
                sel_d = SEL_OFF;
            end
        end
    end

    // State and output registers; reset wins over load and aborts any slot.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            sel_q         <= SEL_OFF;
            frame_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            sel_q         <= sel_d;
            frame_q       <= frame_d;
        end
    end

    assign o_Segment   = seg_q;
    assign o_DP        = dp_q;
    assign o_Digit_Sel = sel_q;
    assign o_Frame     = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb_seven_seg_scan_mux
// Drives two copies of the scan driver (leading-zero blanking off and on)
// from shared inputs. Each scenario pushes the expected per-slot outputs into
// a scoreboard queue; the clock task pops an entry at every slot advance and
// requires the outputs to hold that entry until the next advance.
module tb_seven_seg_scan_mux;

    localparam int ND  = 4;
    localparam int CPD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            load;
    logic [4*ND-1:0] data;
    logic [ND-1:0]   dp;
    logic [ND-1:0]   en;

    logic [6:0]    a_seg, b_seg;
    logic          a_dp, b_dp;
    logic [ND-1:0] a_sel, b_sel;
    logic          a_frame, b_frame;

    typedef struct packed {
        logic [6:0]    a_seg;
        logic [ND-1:0] a_sel;
        logic          a_dp;
        logic [6:0]    b_seg;
        logic [ND-1:0] b_sel;
        logic          b_dp;
        logic          frame;
    } slot_t;

    localparam slot_t INACTIVE = '{7'h7F, 4'hF, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0};

    slot_t sb_q[$];
    slot_t hold;
    int    model_cnt;
    int    total;
    int    bad;
    string cur_test;

    // Free-running bench clock.
    always #5 clk = ~clk;

    seven_seg_scan_mux #(
        .NUM_DIGITS(ND), .CLKS_PER_DIGIT(CPD), .ACTIVE_LOW_SEG(1'b1),
        .ACTIVE_LOW_DIG(1'b1), .BLANK_LEADING(1'b0)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Data(data), .i_DP(dp),
        .i_Digit_En(en), .o_Segment(a_seg), .o_DP(a_dp),
        .o_Digit_Sel(a_sel), .o_Frame(a_frame)
    );

    seven_seg_scan_mux #(
        .NUM_DIGITS(ND), .CLKS_PER_DIGIT(CPD), .ACTIVE_LOW_SEG(1'b1),
        .ACTIVE_LOW_DIG(1'b1), .BLANK_LEADING(1'b1)
    ) dut_bl (
        .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Data(data), .i_DP(dp),
        .i_Digit_En(en), .o_Segment(b_seg), .o_DP(b_dp),
        .o_Digit_Sel(b_sel), .o_Frame(b_frame)
    );

    function automatic slot_t mk(input logic [6:0] as, input logic [ND-1:0] asel,
                                 input logic adp, input logic [6:0] bs,
                                 input logic [ND-1:0] bsel, input logic bdp,
                                 input logic fr);
        slot_t s;
        s.a_seg = as;  s.a_sel = asel; s.a_dp = adp;
        s.b_seg = bs;  s.b_sel = bsel; s.b_dp = bdp;
        s.frame = fr;
        return s;
    endfunction

    function automatic slot_t same(input logic [6:0] s, input logic [ND-1:0] sel,
                                   input logic d, input logic fr);
        return mk(s, sel, d, s, sel, d, fr);
    endfunction

    // One clock: track the slot timer, pop an expectation on each advance,
    // then compare both instances #1 after the edge.
    task automatic tick();
        logic  adv;
        logic  was_rst;
        logic  exp_frame;
        @(posedge clk);
        was_rst = rst;
        adv     = !rst && (model_cnt == CPD - 1);
        if (rst || adv) model_cnt = 0;
        else            model_cnt++;
        #1;
        exp_frame = 1'b0;
        if (was_rst) begin
            hold = INACTIVE;
        end else if (adv) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL %s sb_underflow got=advance_without_entry exp=entry", cur_test);
            end else begin
                hold      = sb_q.pop_front();
                exp_frame = hold.frame;
            end
        end
        total++;
        if (a_seg !== hold.a_seg) begin
            bad++; $display("[TB] FAIL %s a_seg got=%h exp=%h", cur_test, a_seg, hold.a_seg);
        end
        total++;
        if (a_sel !== hold.a_sel) begin
            bad++; $display("[TB] FAIL %s a_sel got=%h exp=%h", cur_test, a_sel, hold.a_sel);
        end
        total++;
        if (a_dp !== hold.a_dp) begin
            bad++; $display("[TB] FAIL %s a_dp got=%b exp=%b", cur_test, a_dp, hold.a_dp);
        end
        total++;
        if (a_frame !== exp_frame) begin
            bad++; $display("[TB] FAIL %s a_frame got=%b exp=%b", cur_test, a_frame, exp_frame);
        end
        total++;
        if (b_seg !== hold.b_seg) begin
            bad++; $display("[TB] FAIL %s b_seg got=%h exp=%h", cur_test, b_seg, hold.b_seg);
        end
        total++;
        if (b_sel !== hold.b_sel) begin
            bad++; $display("[TB] FAIL %s b_sel got=%h exp=%h", cur_test, b_sel, hold.b_sel);
        end
        total++;
        if (b_dp !== hold.b_dp) begin
            bad++; $display("[TB] FAIL %s b_dp got=%b exp=%b", cur_test, b_dp, hold.b_dp);
        end
        total++;
        if (b_frame !== exp_frame) begin
            bad++; $display("[TB] FAIL %s b_frame got=%b exp=%b", cur_test, b_frame, exp_frame);
        end
    endtask

    // Clock until every queued slot has been seen, with a cycle budget.
    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL %s drain_timeout got=%0d_left exp=0_left", cur_test, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        repeat (2) tick();
        rst  = 1'b0;
    endtask

    task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Reset forces inactive pins and overrides a concurrent load.
    task automatic test_reset();
        cur_test = "reset";
        rst  = 1'b1;
        load = 1'b1;
        data = 16'h12AF;
        dp   = 4'hF;
        tick();
        tick();
        total++;
        if (a_seg !== 7'h7F || a_sel !== 4'hF || a_dp !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_pins got=%h/%h/%b exp=7f/f/1", a_seg, a_sel, a_dp);
        end
        rst  = 1'b0;
        load = 1'b0;
        sb_q.push_back(same(7'h40, 4'hE, 1'b1, 1'b1));
        sb_q.push_back(mk(7'h40, 4'hD, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'hB, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'h7, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        drain();
    endtask

    // Two full frames of 12AF; frame strobe only on digit 0.
    task automatic test_basic_scan();
        cur_test = "basic_scan";
        do_reset();
        do_load(16'h12AF, 4'h0);
        for (int f = 0; f < 2; f++) begin
            sb_q.push_back(same(7'h0E, 4'hE, 1'b1, 1'b1));
            sb_q.push_back(same(7'h08, 4'hD, 1'b1, 1'b0));
            sb_q.push_back(same(7'h24, 4'hB, 1'b1, 1'b0));
            sb_q.push_back(same(7'h79, 4'h7, 1'b1, 1'b0));
        end
        drain();
    endtask

    // Leading-zero blanking, then an all-zero word loaded mid-scan.
    task automatic test_blank_leading();
        cur_test = "blank_leading";
        do_reset();
        do_load(16'h0050, 4'h0);
        sb_q.push_back(same(7'h40, 4'hE, 1'b1, 1'b1));
        sb_q.push_back(same(7'h12, 4'hD, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'hB, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'h7, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        drain();
        do_load(16'h0000, 4'h0);
        sb_q.push_back(same(7'h40, 4'hE, 1'b1, 1'b1));
        sb_q.push_back(mk(7'h40, 4'hD, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'hB, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'h7, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        drain();
    endtask

    // Disabled digits blank their slot without shortening it.
    task automatic test_digit_enable();
        cur_test = "digit_enable";
        do_reset();
        en = 4'b0101;
        do_load(16'h1234, 4'h0);
        sb_q.push_back(same(7'h19, 4'hE, 1'b1, 1'b1));
        sb_q.push_back(same(7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(same(7'h24, 4'hB, 1'b1, 1'b0));
        sb_q.push_back(same(7'h7F, 4'hF, 1'b1, 1'b0));
        drain();
        en = 4'hF;
    endtask

    // A load landing on an advance cycle is seen one slot later.
    task automatic test_back_to_back();
        int n;
        cur_test = "load_on_advance";
        do_reset();
        do_load(16'h1111, 4'h0);
        sb_q.push_back(same(7'h79, 4'hE, 1'b1, 1'b1));
        drain();
        n = 0;
        while (model_cnt != CPD - 1 && n < 20) begin
            tick();
            n++;
        end
        sb_q.push_back(same(7'h79, 4'hD, 1'b1, 1'b0));
        sb_q.push_back(same(7'h00, 4'hB, 1'b1, 1'b0));
        sb_q.push_back(same(7'h00, 4'h7, 1'b1, 1'b0));
        sb_q.push_back(same(7'h00, 4'hE, 1'b1, 1'b1));
        do_load(16'h8888, 4'h0);
        drain();
    endtask

    // Decimal point follows its own digit only.
    task automatic test_decimal_point();
        cur_test = "decimal_point";
        do_reset();
        do_load(16'h1234, 4'b0010);
        sb_q.push_back(same(7'h19, 4'hE, 1'b1, 1'b1));
        sb_q.push_back(same(7'h30, 4'hD, 1'b0, 1'b0));
        sb_q.push_back(same(7'h24, 4'hB, 1'b1, 1'b0));
        sb_q.push_back(same(7'h79, 4'h7, 1'b1, 1'b0));
        drain();
    endtask

    // Reset in the middle of digit 2's slot, racing a load.
    task automatic test_reset_mid_scan();
        cur_test = "reset_mid_scan";
        do_reset();
        do_load(16'h1234, 4'h0);
        sb_q.push_back(same(7'h19, 4'hE, 1'b1, 1'b1));
        sb_q.push_back(same(7'h30, 4'hD, 1'b1, 1'b0));
        sb_q.push_back(same(7'h24, 4'hB, 1'b1, 1'b0));
        drain();
        tick();
        rst  = 1'b1;
        load = 1'b1;
        data = 16'h5678;
        dp   = 4'hF;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        sb_q.push_back(same(7'h40, 4'hE, 1'b1, 1'b1));
        sb_q.push_back(mk(7'h40, 4'hD, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'hB, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        sb_q.push_back(mk(7'h40, 4'h7, 1'b1, 7'h7F, 4'hF, 1'b1, 1'b0));
        drain();
    endtask

    // Scenario sequence and summary.
    initial begin
        total     = 0;
        bad       = 0;
        model_cnt = 0;
        hold      = INACTIVE;
        cur_test  = "init";
        rst       = 1'b1;
        load      = 1'b0;
        data      = '0;
        dp        = '0;
        en        = 4'hF;
        test_reset();
        test_basic_scan();
        test_blank_leading();
        test_digit_enable();
        test_back_to_back();
        test_decimal_point();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
